ds_wb_buffer: RTL and testbench

- Writeback stage directly downstream of the divide-subtract datapath (ds).
- Captures each {quotient, difference} result pair with a valid/ready handshake and derives two status flags per entry.
- Buffers entries in a small in-order FIFO and presents them to the register-file writeback port with valid/ready.
- Absorbs writeback stalls so the datapath result is never lost.

---
 rtl/ds_pkg.sv | 13 +
 rtl/ds_wb_regfile.sv | 17 +
 rtl/ds_wb_buffer.sv | 74 +++++++
 tb/tb_ds_wb_buffer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// ds_pkg: shared width, writeback entry type and flag helper for the ds writeback path
package ds_pkg;
  localparam int DS_DATA_W = 32;
  typedef struct packed {
    logic [DS_DATA_W-1:0] quotient;
    logic [DS_DATA_W-1:0] difference;
    logic                 zero;
    logic                 neg;
  } ds_wb_entry_t;
  function automatic ds_wb_entry_t ds_make_entry(input logic [DS_DATA_W-1:0] q, input logic [DS_DATA_W-1:0] d);
    ds_make_entry = '{quotient: q, difference: d, zero: (d == '0), neg: d[DS_DATA_W-1]};
  endfunction
endpackage

// File: rtl/ds_wb_regfile.sv
// ds_wb_regfile: DEPTH x W storage, one sync write port (we/waddr/wdata), one async read port (raddr/rdata)
module ds_wb_regfile #(
  parameter int W     = 66,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ds_wb_buffer.sv
// ds_wb_buffer: in-order writeback FIFO for ds {quotient,difference} results with zero/neg flags; ports clk,rst(async),flush,in_* (valid/ready),out_* (valid/ready),count; DS_WB_PERF_EN adds perf_pushes/perf_stalls
module ds_wb_buffer
  import ds_pkg::*;
#(
  parameter int DATA_W = DS_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_quotient,
  input  logic [DATA_W-1:0]        in_difference,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_quotient,
  output logic [DATA_W-1:0]        out_difference,
  output logic                     out_zero,
  output logic                     out_neg,
`ifdef DS_WB_PERF_EN
  output logic [31:0]              perf_pushes,
  output logic [31:0]              perf_stalls,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * DATA_W + 2;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [EW-1:0] wentry, rentry;
  assign in_ready  = !rst && (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign wentry    = {in_quotient, in_difference, (in_difference == '0), in_difference[DATA_W-1]};
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  ds_wb_regfile #(.W(EW), .DEPTH(DEPTH)) u_rf (
    .clk  (clk),
    .we   (push && !flush),
    .waddr(wr_ptr_q),
    .wdata(wentry),
    .raddr(rd_ptr_q),
    .rdata(rentry)
  );
  assign {out_quotient, out_difference, out_zero, out_neg} = out_valid ? rentry : '0;
`ifdef DS_WB_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_pushes <= '0;
      perf_stalls <= '0;
    end else begin
      perf_pushes <= perf_pushes + 32'(push);
      perf_stalls <= perf_stalls + 32'(in_valid && !in_ready);
    end
`endif
endmodule

// File: tb/tb_ds_wb_buffer.sv
// tb_ds_wb_buffer: randomized and directed scoreboard bench for ds_wb_buffer
module tb_ds_wb_buffer;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [DW-1:0] in_q = '0, in_d = '0;
  logic in_ready, out_valid, out_zero, out_neg;
  logic [DW-1:0] out_q, out_d;
  logic [2:0] count;
`ifdef DS_WB_PERF_EN
  logic [31:0] perf_pushes, perf_stalls;
`endif
  typedef struct { logic [DW-1:0] q; logic [DW-1:0] d; } ent_t;
  ent_t sb[$];
  int checks = 0, errors = 0;
  int exp_pushes = 0, exp_stalls = 0;
  always #5 clk = ~clk;
  ds_wb_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_quotient(in_q), .in_difference(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_q), .out_difference(out_d),
    .out_zero(out_zero), .out_neg(out_neg),
`ifdef DS_WB_PERF_EN
    .perf_pushes(perf_pushes), .perf_stalls(perf_stalls),
`endif
    .count(count)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_count", 64'(count), 0);
      chk("rst_out_data", {out_q, out_d}, 0);
      chk("rst_flags", {out_zero, out_neg}, 0);
      sb.delete();
      exp_pushes = 0;
      exp_stalls = 0;
    end else begin
      automatic bit full = (sb.size() == DEPTH);
      automatic bit accept = in_valid && !full;
      chk("count", 64'(count), 64'(sb.size()));
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(!full));
      if (sb.size() != 0) begin
        chk("out_data", {out_q, out_d}, {sb[0].q, sb[0].d});
        chk("out_zero", 64'(out_zero), 64'(sb[0].d == 0));
        chk("out_neg", 64'(out_neg), 64'(sb[0].d[DW-1]));
      end else begin
        chk("empty_data", {out_q, out_d, 30'd0, out_zero, out_neg}, 0);
      end
`ifdef DS_WB_PERF_EN
      chk("perf_pushes", 64'(perf_pushes), 64'(exp_pushes));
      chk("perf_stalls", 64'(perf_stalls), 64'(exp_stalls));
`endif
      if (accept) exp_pushes++;
      if (in_valid && full) exp_stalls++;
      if (flush) sb.delete();
      else begin
        if (out_ready && sb.size() != 0) void'(sb.pop_front());
        if (accept) sb.push_back('{q: in_q, d: in_d});
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit v, input logic [DW-1:0] q, input logic [DW-1:0] d, input bit r);
    in_valid = v;
    in_q = q;
    in_d = d;
    out_ready = r;
    step();
  endtask
  initial begin
    repeat (3) step();
    rst = 0;
    step();
    drive(1, 32'h7, 32'h0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 32'(100 + i), (i == 0) ? 32'hFFFF_FFFE : 32'(i), 0);
    drive(1, 32'd104, 32'd4, 0);
    drive(1, 32'd104, 32'd4, 0);
    repeat (6) drive(0, 0, 0, 1);
    repeat (2) drive(1, $urandom, $urandom, 0);
    for (int i = 0; i < 20; i++) drive(1, 32'(200 + i), $urandom, 1);
    repeat (3) drive(0, 0, 0, 1);
    repeat (3) drive(1, $urandom, 0, 0);
    flush = 1;
    drive(1, 32'hDEAD_BEEF, 32'h8000_0000, 0);
    flush = 0;
    drive(0, 0, 0, 0);
    drive(1, 32'h55, 32'h1, 0);
    repeat (3) drive(0, 0, 0, 1);
    repeat (2) drive(1, $urandom, $urandom, 0);
    #2 rst = 1;
    step();
    rst = 0;
    step();
    for (int i = 0; i < 600; i++) begin
      automatic int k = $urandom_range(0, 3);
      flush = ($urandom_range(0, 29) == 0);
      drive($urandom_range(0, 2) != 0, $urandom, (k == 0) ? 32'h0 : (k == 1) ? (32'h8000_0000 | $urandom) : $urandom,
            $urandom_range(0, 2) == 0 || i > 580);
    end
    flush = 0;
    repeat (6) drive(0, 0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
